// File: rtl/feature_serializer_pkg.sv
// feature_pkg: shared types and constants for the feature serializer slice.
// Holds the FSM state encoding, the stream tags and the word-size helpers.
package feature_pkg;

  // Serializer FSM states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HEADER  = 2'd1,
    PAYLOAD = 2'd2,
    TRAILER = 2'd3
  } state_t;

  localparam logic [7:0] TRAILER_TAG = 8'hFE;
  localparam logic [7:0] DROP_TAG    = 8'hFD;
  localparam int         WORD_BITS   = 32;

  localparam int DESCRIPTOR_BITS_DEFAULT = 256;
  localparam int WORDS_PER_DESC          = DESCRIPTOR_BITS_DEFAULT / WORD_BITS;

  // Number of stream words needed for a descriptor of the given width
  function automatic int words_per_desc(input int desc_bits);
    return desc_bits / WORD_BITS;
  endfunction

endpackage

// File: rtl/feature_serializer_counter.sv
// frame_feature_counter: per-frame bookkeeping for the feature serializer.
// Tracks promised (expected), popped (received), sent (emitted) and discarded
// (dropped) features, the latched cap and the end-of-frame flag.
module frame_feature_counter
  import feature_pkg::*;
#(
  parameter int COUNT_BITS = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  frame_start,
  input  logic [COUNT_BITS-1:0] cap_load,
  input  logic                  corner_inc,
  input  logic                  frame_end,
  input  logic                  consume,
  input  logic                  emit,
  input  logic                  drop,
  input  logic                  trailer_done,
  output logic [COUNT_BITS-1:0] emitted,
  output logic [COUNT_BITS-1:0] dropped,
  output logic                  frame_end_seen,
  output logic                  drained,
  output logic                  under_cap
);

  localparam logic [COUNT_BITS-1:0] ALL_ONES = '1;
  localparam logic [COUNT_BITS-1:0] ONE      = COUNT_BITS'(1);

  logic [COUNT_BITS-1:0] expected_reg;
  logic [COUNT_BITS-1:0] received_reg;
  logic [COUNT_BITS-1:0] emitted_reg;
  logic [COUNT_BITS-1:0] dropped_reg;
  logic [COUNT_BITS-1:0] cap_reg;
  logic                  frame_end_seen_reg;

  // Frame start wins over every same-cycle event; otherwise counters advance independently
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      expected_reg       <= '0;
      received_reg       <= '0;
      emitted_reg        <= '0;
      dropped_reg        <= '0;
      cap_reg            <= '0;
      frame_end_seen_reg <= 1'b0;
    end else if (frame_start) begin
      expected_reg       <= '0;
      received_reg       <= '0;
      emitted_reg        <= '0;
      dropped_reg        <= '0;
      cap_reg            <= cap_load;
      frame_end_seen_reg <= 1'b0;
    end else begin
      if (corner_inc && (expected_reg != ALL_ONES)) begin
        expected_reg <= expected_reg + ONE;
      end
      if (consume) begin
        received_reg <= received_reg + ONE;
      end
      if (emit) begin
        emitted_reg <= emitted_reg + ONE;
      end
      if (drop && (dropped_reg != ALL_ONES)) begin
        dropped_reg <= dropped_reg + ONE;
      end
      // A late frame_end must not be lost to the trailer of the same frame
      if (frame_end) begin
        frame_end_seen_reg <= 1'b1;
      end else if (trailer_done) begin
        frame_end_seen_reg <= 1'b0;
      end
    end
  end

  assign emitted        = emitted_reg;
  assign dropped        = dropped_reg;
  assign frame_end_seen = frame_end_seen_reg;
  // An overrun (received > expected) never reads as drained, so no trailer is sent
  assign drained        = (received_reg == expected_reg);
  assign under_cap      = (emitted_reg < cap_reg);

endmodule

// File: rtl/feature_serializer.sv
// feature_serializer: pops finished features (x, y, descriptor) from the
// upstream FIFO and streams them as 32-bit words (header, then descriptor
// words LSW first), followed by one trailer word per frame once every
// promised feature has drained. Features over the per-frame cap are discarded.
// Optional build macro FEATURE_SERIALIZER_DROPCOUNT_EN adds a second trailer
// word carrying the drop count.
module feature_serializer
  import feature_pkg::*;
#(
  parameter int COORD_BITS      = 11,
  parameter int DESCRIPTOR_BITS = DESCRIPTOR_BITS_DEFAULT,
  parameter int COUNT_BITS      = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_frame_start,
  input  logic [COUNT_BITS-1:0]      r_max_features,
  input  logic                       in_corner_increment,
  input  logic                       in_frame_end,
  input  logic                       in_valid,
  input  logic [DESCRIPTOR_BITS-1:0] in_descriptor,
  input  logic [COORD_BITS-1:0]      in_x,
  input  logic [COORD_BITS-1:0]      in_y,
  output logic                       out_consume,
  output logic [WORD_BITS-1:0]       out_data,
  output logic                       out_valid,
  input  logic                       in_ready,
  output logic                       out_last,
  output logic [COUNT_BITS-1:0]      out_dropped
);

  localparam int WORDS     = words_per_desc(DESCRIPTOR_BITS);
  localparam int IDX_BITS  = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int COORD_PAD = 16 - COORD_BITS;

  localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(WORDS - 1);
  localparam logic [IDX_BITS-1:0] IDX_ONE  = IDX_BITS'(1);

  state_t                     state_reg;
  logic [DESCRIPTOR_BITS-1:0] desc_reg;
  logic [IDX_BITS-1:0]        word_idx_reg;
  logic                       stale_reg;
`ifdef FEATURE_SERIALIZER_DROPCOUNT_EN
  logic                       trailer_second_reg;
`endif

  logic [COUNT_BITS-1:0] emitted;
  logic                  frame_end_seen;
  logic                  drained;
  logic                  under_cap;

  logic                  idle_ok;
  logic                  pop_emit;
  logic                  pop_drop;
  logic                  start_trailer;
  logic                  emit_pulse;
  logic                  trailer_done;
  logic [WORD_BITS-1:0]  header_word;
  logic [WORD_BITS-1:0]  trailer_word;

  // No pop on the cycle after a pop (FIFO head update) nor on a frame-start cycle
  assign idle_ok       = (state_reg == IDLE) && !in_frame_start && !out_consume;
  assign pop_emit      = idle_ok && in_valid && under_cap;
  assign pop_drop      = idle_ok && in_valid && !under_cap;
  assign start_trailer = idle_ok && !in_valid && frame_end_seen && drained;

  // A header belonging to the previous frame is sent but not counted
  assign emit_pulse    = (state_reg == HEADER) && in_ready && !stale_reg;
  assign trailer_done  = (state_reg == TRAILER) && out_valid && in_ready && out_last;

  assign header_word   = {{COORD_PAD{1'b0}}, in_y, {COORD_PAD{1'b0}}, in_x};
  assign trailer_word  = {TRAILER_TAG, 8'h00, 16'(emitted)};

  frame_feature_counter #(
    .COUNT_BITS(COUNT_BITS)
  ) u_counter (
    .clk            (clk),
    .reset          (reset),
    .frame_start    (in_frame_start),
    .cap_load       (r_max_features),
    .corner_inc     (in_corner_increment),
    .frame_end      (in_frame_end),
    .consume        (out_consume),
    .emit           (emit_pulse),
    .drop           (pop_drop),
    .trailer_done   (trailer_done),
    .emitted        (emitted),
    .dropped        (out_dropped),
    .frame_end_seen (frame_end_seen),
    .drained        (drained),
    .under_cap      (under_cap)
  );

  // Serializer FSM with registered stream outputs and pop strobe
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg          <= IDLE;
      out_valid          <= 1'b0;
      out_consume        <= 1'b0;
      out_last           <= 1'b0;
      out_data           <= '0;
      desc_reg           <= '0;
      word_idx_reg       <= '0;
      stale_reg          <= 1'b0;
`ifdef FEATURE_SERIALIZER_DROPCOUNT_EN
      trailer_second_reg <= 1'b0;
`endif
    end else begin
      out_consume <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (pop_emit) begin
            desc_reg    <= in_descriptor;
            out_data    <= header_word;
            out_valid   <= 1'b1;
            out_last    <= 1'b0;
            out_consume <= 1'b1;
            stale_reg   <= 1'b0;
            state_reg   <= HEADER;
          end else if (pop_drop) begin
            out_consume <= 1'b1;
          end else if (start_trailer) begin
            out_data    <= trailer_word;
            out_valid   <= 1'b1;
`ifdef FEATURE_SERIALIZER_DROPCOUNT_EN
            out_last           <= 1'b0;
            trailer_second_reg <= 1'b0;
`else
            out_last    <= 1'b1;
`endif
            state_reg   <= TRAILER;
          end
        end
        HEADER: begin
          if (in_ready) begin
            out_data     <= desc_reg[WORD_BITS-1:0];
            desc_reg     <= desc_reg >> WORD_BITS;
            word_idx_reg <= '0;
            stale_reg    <= 1'b0;
            state_reg    <= PAYLOAD;
          end else if (in_frame_start) begin
            stale_reg    <= 1'b1;
          end
        end
        PAYLOAD: begin
          if (in_ready) begin
            if (word_idx_reg == LAST_IDX) begin
              out_valid <= 1'b0;
              state_reg <= IDLE;
            end else begin
              out_data     <= desc_reg[WORD_BITS-1:0];
              desc_reg     <= desc_reg >> WORD_BITS;
              word_idx_reg <= word_idx_reg + IDX_ONE;
            end
          end
        end
        TRAILER: begin
          if (in_ready) begin
`ifdef FEATURE_SERIALIZER_DROPCOUNT_EN
            if (!trailer_second_reg) begin
              out_data           <= {DROP_TAG, 8'h00, 16'(out_dropped)};
              out_last           <= 1'b1;
              trailer_second_reg <= 1'b1;
            end else begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              state_reg <= IDLE;
            end
`else
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            state_reg <= IDLE;
`endif
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_feature_serializer.sv
// tb_feature_serializer: randomized and directed frames checked against a
// queue-based reference of the expected word stream, pop count and drop count.
`timescale 1ns/1ps
module tb_feature_serializer;

  localparam int CB = 11;
  localparam int DB = 256;
  localparam int NB = 16;
  localparam int NW = DB / 32;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          in_frame_start = 1'b0;
  logic [NB-1:0] r_max_features = '0;
  logic          in_corner_increment = 1'b0;
  logic          in_frame_end = 1'b0;
  logic          in_valid = 1'b0;
  logic [DB-1:0] in_descriptor = '0;
  logic [CB-1:0] in_x = '0;
  logic [CB-1:0] in_y = '0;
  logic          out_consume;
  logic [31:0]   out_data;
  logic          out_valid;
  logic          in_ready = 1'b1;
  logic          out_last;
  logic [NB-1:0] out_dropped;

  always #5 clk = ~clk;

  feature_serializer #(
    .COORD_BITS(CB), .DESCRIPTOR_BITS(DB), .COUNT_BITS(NB)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .in_frame_start      (in_frame_start),
    .r_max_features      (r_max_features),
    .in_corner_increment (in_corner_increment),
    .in_frame_end        (in_frame_end),
    .in_valid            (in_valid),
    .in_descriptor       (in_descriptor),
    .in_x                (in_x),
    .in_y                (in_y),
    .out_consume         (out_consume),
    .out_data            (out_data),
    .out_valid           (out_valid),
    .in_ready            (in_ready),
    .out_last            (out_last),
    .out_dropped         (out_dropped)
  );

  typedef struct packed {
    logic [CB-1:0] x;
    logic [CB-1:0] y;
    logic [DB-1:0] desc;
  } feat_t;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } word_t;

  feat_t fifo_q[$];
  word_t exp_q[$];

  int    n_cmp = 0;
  int    n_bad = 0;
  int    n_consume = 0;
  int    xfer_count = 0;
  int    ready_mode = 0;
  int    ready_phase = 0;
  bit    monitor_en = 1'b0;
  int    base_consume = 0;
  int    base_xfer = 0;
  int    exp_words = 0;
  int    exp_dropped = 0;

  logic        stall_pend = 1'b0;
  logic [31:0] held_data = '0;
  logic        held_last = 1'b0;
  word_t       mon_e;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Upstream FIFO model: pop on the strobe, present the head mid-cycle
  always @(negedge clk) begin
    if (reset && out_consume === 1'b1) begin
      n_consume++;
      if (fifo_q.size() > 0) void'(fifo_q.pop_front());
    end
    if (fifo_q.size() > 0) begin
      in_valid      = 1'b1;
      in_x          = fifo_q[0].x;
      in_y          = fifo_q[0].y;
      in_descriptor = fifo_q[0].desc;
    end else begin
      in_valid = 1'b0;
    end
  end

  // Downstream ready: always, random, or the repeating 1,0,0,1 pattern
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: in_ready = 1'b1;
      1: in_ready = 1'($urandom_range(0, 1));
      default: begin
        in_ready = ((ready_phase % 4) == 0) || ((ready_phase % 4) == 3);
        ready_phase++;
      end
    endcase
  end

  // Stream monitor: stall stability and in-order word comparison
  always @(negedge clk) begin
    if (monitor_en) begin
      if (stall_pend) begin
        check_val("stall_valid", 32'(out_valid), 32'd1);
        check_val("stall_data", out_data, held_data);
        check_val("stall_last", 32'(out_last), 32'(held_last));
      end
      stall_pend = out_valid && !in_ready;
      held_data  = out_data;
      held_last  = out_last;
      if (out_valid && in_ready) begin
        xfer_count++;
        if (exp_q.size() == 0) begin
          check_val("extra_xfer", 32'(out_valid), 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          $display("xfer %0d: data %h last %0d (ref %h/%0d)", xfer_count, out_data, out_last, mon_e.data, mon_e.last);
          check_val("word", out_data, mon_e.data);
          check_val("last", 32'(out_last), 32'(mon_e.last));
        end
      end
    end else begin
      stall_pend = 1'b0;
    end
  end

  // Start a frame, announce n corners, end it, then deliver features after 'late' cycles
  task automatic setup_frame(input int n, input int cap, input bit simul, input int late, input bit directed);
    feat_t feats[$];
    feat_t f;
    word_t w;
    int kept;
    for (int i = 0; i < n; i++) begin
      f.x = CB'($urandom);
      f.y = CB'($urandom);
      for (int k = 0; k < NW; k++) f.desc[32*k +: 32] = $urandom;
      if (directed && i == 0) begin
        f.x = CB'(5);
        f.y = CB'(7);
        f.desc = '0;
        f.desc[31:0] = 32'h0000_0001;
        f.desc[DB-1 -: 32] = 32'hDEAD_BEEF;
      end
      feats.push_back(f);
    end
    kept = (n < cap) ? n : cap;
    exp_dropped = n - kept;
    exp_words = 0;
    for (int i = 0; i < kept; i++) begin
      w.data = (32'(feats[i].y) << 16) | 32'(feats[i].x);
      w.last = 1'b0;
      exp_q.push_back(w);
      for (int k = 0; k < NW; k++) begin
        w.data = 32'(feats[i].desc >> (32 * k));
        exp_q.push_back(w);
      end
      exp_words += 1 + NW;
    end
`ifdef FEATURE_SERIALIZER_DROPCOUNT_EN
    w.data = (32'hFE << 24) | 32'(kept);
    w.last = 1'b0;
    exp_q.push_back(w);
    w.data = (32'hFD << 24) | 32'(exp_dropped);
    w.last = 1'b1;
    exp_q.push_back(w);
    exp_words += 2;
`else
    w.data = (32'hFE << 24) | 32'(kept);
    w.last = 1'b1;
    exp_q.push_back(w);
    exp_words += 1;
`endif
    base_consume = n_consume;
    base_xfer    = xfer_count;
    r_max_features = NB'(cap);
    in_frame_start = 1'b1;
    step();
    in_frame_start = 1'b0;
    for (int i = 0; i < n; i++) begin
      in_corner_increment = 1'b1;
      if (simul && i == n - 1) in_frame_end = 1'b1;
      step();
      in_corner_increment = 1'b0;
      in_frame_end = 1'b0;
    end
    if (!(simul && n > 0)) begin
      in_frame_end = 1'b1;
      step();
      in_frame_end = 1'b0;
    end
    repeat (late) step();
    foreach (feats[i]) fifo_q.push_back(feats[i]);
  endtask

  task automatic finish_frame(input string name, input int n);
    int cycles = 0;
    while (exp_q.size() > 0 && cycles < 4000) begin
      step();
      cycles++;
    end
    check_val("drain", 32'(exp_q.size()), 32'd0);
    repeat (15) step();
    check_val("consumes", 32'(n_consume - base_consume), 32'(n));
    check_val("xfers", 32'(xfer_count - base_xfer), 32'(exp_words));
    check_val("dropped", 32'(out_dropped), 32'(exp_dropped));
    check_val("idle_valid", 32'(out_valid), 32'd0);
    $display("frame %s: n=%0d words=%0d dropped=%0d done", name, n, exp_words, exp_dropped);
  endtask

  task automatic run_frame(input string name, input int n, input int cap, input bit simul,
                           input int late, input bit directed);
    setup_frame(n, cap, simul, late, directed);
    finish_frame(name, n);
  endtask

  initial begin
    int n, cap, cycles;
    repeat (3) step();
    check_val("rst_valid", 32'(out_valid), 32'd0);
    check_val("rst_consume", 32'(out_consume), 32'd0);
    check_val("rst_last", 32'(out_last), 32'd0);
    check_val("rst_data", out_data, 32'd0);
    check_val("rst_dropped", 32'(out_dropped), 32'd0);
    reset = 1'b1;
    monitor_en = 1'b1;
    repeat (2) step();

    ready_mode = 0;
    run_frame("single", 1, 16, 1'b0, 0, 1'b1);
    ready_mode = 2;
    run_frame("backpressure", 1, 16, 1'b0, 3, 1'b0);
    ready_mode = 0;
    run_frame("cap", 4, 2, 1'b0, 0, 1'b0);
    run_frame("late_drain", 3, 16, 1'b0, 50, 1'b0);
    run_frame("simultaneous", 1, 16, 1'b1, 30, 1'b0);
    run_frame("empty", 0, 16, 1'b0, 0, 1'b0);
    run_frame("cap_zero", 3, 0, 1'b0, 0, 1'b0);

    // Reset while PAYLOAD word 4 is on the bus
    setup_frame(1, 16, 1'b0, 0, 1'b0);
    cycles = 0;
    while ((xfer_count - base_xfer) < 5 && cycles < 400) begin
      step();
      cycles++;
    end
    check_val("reach_payload4", 32'(xfer_count - base_xfer), 32'd5);
    #1;
    reset = 1'b0;
    monitor_en = 1'b0;
    #1;
    check_val("midrst_valid", 32'(out_valid), 32'd0);
    check_val("midrst_data", out_data, 32'd0);
    check_val("midrst_last", 32'(out_last), 32'd0);
    exp_q.delete();
    fifo_q.delete();
    repeat (2) step();
    reset = 1'b1;
    monitor_en = 1'b1;
    repeat (3) step();
    check_val("postrst_valid", 32'(out_valid), 32'd0);
    check_val("postrst_consume", 32'(out_consume), 32'd0);
    run_frame("after_reset", 2, 16, 1'b0, 0, 1'b0);

    ready_mode = 1;
    for (int f = 0; f < 8; f++) begin
      n   = $urandom_range(0, 5);
      cap = $urandom_range(0, 6);
      run_frame("random", n, cap, 1'($urandom_range(0, 1)), $urandom_range(0, 20), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global watchdog so the run always terminates
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/feature_serializer.md
Name: feature_serializer

Overview:
- Downstream of the corner/descriptor stage. Pops finished features (x, y, 256-bit descriptor) from that stage's output FIFO.
- Serialises each feature into 32-bit words on a valid/ready stream, for the DMA/host writer.
- Tracks how many corners the frame promised against how many it received. Emits one trailer word once the frame has ended and every promised descriptor has drained.
- Enforces a per-frame feature cap. Features over the cap are popped and discarded.

Parameters:
- COORD_BITS, 11, width of x/y coordinates; must be ≤15.
- DESCRIPTOR_BITS, 256, descriptor width; must be a multiple of 32.
- COUNT_BITS, 16, width of the per-frame counters; must be ≤16.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- in_frame_start  in  1  one-cycle pulse; starts a new frame and clears all counters.
- r_max_features  in  COUNT_BITS  per-frame emit cap; sampled on in_frame_start.
- in_corner_increment  in  1  pulse: one more descriptor will arrive this frame.
- in_frame_end  in  1  pulse: no further corner increments this frame.
- in_valid  in  1  upstream FIFO is non-empty.
- in_descriptor  in  DESCRIPTOR_BITS  FIFO head descriptor.
- in_x, in_y  in  COORD_BITS  FIFO head coordinates.
- out_consume  out  1  one-cycle pop strobe to the upstream FIFO.
- out_data  out  32  stream word.
- out_valid  out  1  out_data is valid.
- in_ready  in  1  downstream accepts the word.
- out_last  out  1  marks the last word of the frame (the trailer).
- out_dropped  out  COUNT_BITS  features discarded this frame; saturating.

Behaviour:
- Async reset (reset low): state IDLE. out_valid=0, out_consume=0, out_last=0, out_data=0, out_dropped=0. All counters=0; frame_end_seen=0; cap=0.
- A word transfers on a cycle where out_valid && in_ready. out_data and out_last stay stable while out_valid && !in_ready.
- Counters:
  - expected: increments on in_corner_increment and saturates at all-ones.
  - received: increments on every out_consume.
  - emitted: counts features whose header was sent.
- in_frame_start clears all counters, frame_end_seen and out_dropped, and loads cap. It has priority over any increment on the same cycle. A record already in flight completes, but it is not counted in the new frame.
- in_frame_end sets frame_end_seen. An in_corner_increment on the same cycle is still counted.
- IDLE, checked in priority order:
  1. in_valid && emitted<cap: latch x, y and descriptor; pulse out_consume; go to HEADER.
  2. in_valid && emitted≥cap: pulse out_consume, increment out_dropped, stay in IDLE.
  3. frame_end_seen && received==expected && !in_valid: go to TRAILER.
- Pop rate: out_consume fires at most once per cycle. It is never high on two consecutive cycles, which leaves one cycle for FIFO head update.
- HEADER:
  - out_data = {1'b0, zero-extended y (15b), 1'b0, zero-extended x (15b)} = {y16, x16}.
  - On transfer: emitted++, word index=0, go to PAYLOAD.
- PAYLOAD:
  - Sends DESCRIPTOR_BITS/32 words, least-significant word first.
  - After the last word transfers, go to IDLE.
- TRAILER:
  - out_data = {8'hFE, 8'h00, emitted zero-extended to 16}; out_last=1.
  - On transfer: clear frame_end_seen, go to IDLE.
  - Counters are held until the next in_frame_start.
- Latency: header is valid on the cycle after the pop. A feature with constant in_ready takes 1+8 cycles, so the minimum is 10 cycles between pops.
- Boundaries:
  - cap=0 drops every feature; the trailer reports 0.
  - If received overruns expected (upstream fault), the trailer is never sent until in_frame_start.
  - in_frame_end with expected==0 sends the trailer on the next IDLE cycle.
  - Reset mid-record abandons the record; no partial word is held.

Optional Feature:
- Macro: FEATURE_SERIALIZER_DROPCOUNT_EN.
- Defined: TRAILER is two words.
  - Word 1 = {8'hFE, 8'h00, emitted}, out_last=0.
  - Word 2 = {8'hFD, 8'h00, out_dropped}, out_last=1.
- Undefined: single trailer word as above; the out_dropped port is still present.

Decomposition:
- Shared package feature_pkg holds:
  - the state enum (IDLE, HEADER, PAYLOAD, TRAILER);
  - localparams TRAILER_TAG=8'hFE, DROP_TAG=8'hFD, WORD_BITS=32;
  - WORDS_PER_DESC = DESCRIPTOR_BITS/WORD_BITS.
- One sub-module: frame_feature_counter, which holds expected/received/emitted/dropped, the saturation logic and the drained flag. The FSM and datapath stay in the top level.

Test Plan:
- Single feature: x=5, y=7, descriptor = 0x00..01 with word 7 = 0xDEADBEEF; in_ready=1; one increment, then frame_end. Required: words 0x00070005, 0x00000001, 0,…, 0xDEADBEEF, then trailer 0xFE000001 with out_last=1. out_consume pulses exactly once.
- Backpressure: in_ready toggles 1,0,0,1 during PAYLOAD. Required: out_data is unchanged while stalled, and exactly 9 transfers are made.
- Cap: cap=2 with 4 features queued. Required: 2 records emitted, out_dropped=2, out_consume pulses 4 times, trailer 0xFE000002.
- Late drain: 3 increments, then frame_end, with descriptors arriving 50 cycles after frame_end. Required: no trailer until the third record completes.
- Simultaneous events: in_corner_increment and in_frame_end on the same cycle. Required: expected=1 and the trailer waits for that feature. A separate case with expected=0 sends trailer 0xFE000000 immediately.
- Reset in PAYLOAD word 4. Required: out_valid=0 in the same cycle, IDLE after release, and the next frame's output is correct.
